ex_mem_stage: RTL

Registered EX/MEM boundary stage of the MIPS pipeline. Captures the ALU result (Y, zero, OF) together with the instruction's destination and memory-control fields, and presents them to the MEM stage through a valid/ready handshake backed by a 2-entry skid buffer. Detects signed-overflow traps from the ALU OF flag, squashes the faulting instruction's side effects, and reports the fault PC to the exception logic.

---
 rtl/ex_mem_stage_if.sv | 59 +++++
 rtl/ex_mem_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_if.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_if : EX/MEM handshake, payload and exception signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ex_mem_stage_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             alu_of;
  logic             of_trap;
  logic [WIDTH-1:0] pc;
  logic [REGW-1:0]  rd;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] store_data;
  logic             flush;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [WIDTH-1:0] out_store_data;
  logic             out_zero;
  logic             out_reg_write;
  logic             out_mem_read;
  logic             out_mem_write;
  logic [REGW-1:0]  out_rd;
  logic             out_killed;

  logic             exc_valid;
  logic [WIDTH-1:0] exc_epc;
  logic             exc_pending;
  logic             exc_ack;

  // master: EX/MEM/exception-logic side; slave: the pipeline stage
  modport master (
    output in_valid, alu_y, alu_zero, alu_of, of_trap, pc, rd,
           reg_write, mem_read, mem_write, store_data, flush, out_ready, exc_ack,
    input  in_ready, out_valid, out_y, out_store_data, out_zero, out_reg_write,
           out_mem_read, out_mem_write, out_rd, out_killed,
           exc_valid, exc_epc, exc_pending
  );

  modport slave (
    input  in_valid, alu_y, alu_zero, alu_of, of_trap, pc, rd,
           reg_write, mem_read, mem_write, store_data, flush, out_ready, exc_ack,
    output in_ready, out_valid, out_y, out_store_data, out_zero, out_reg_write,
           out_mem_read, out_mem_write, out_rd, out_killed,
           exc_valid, exc_epc, exc_pending
  );
endinterface

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage : registered EX/MEM boundary with 2-entry skid and overflow trap
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_mem_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic         clk,
  input  logic         reset,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [REGW-1:0]  rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] store_data;
    logic             killed;
  } entry_t;

  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           new_entry;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             exc_valid_q, exc_valid_d;
  logic             exc_pending_q, exc_pending_d;
  logic [WIDTH-1:0] exc_epc_q, exc_epc_d;

  logic             accept;
  logic             pop;
  logic             trap;
  logic             kill;
  logic             raise;

  always_comb begin
    accept = bus.in_valid & in_ready_q;
    pop    = main_valid_q & bus.out_ready;
    trap   = bus.alu_of & bus.of_trap;
    kill   = trap | exc_pending_q;

    // Squashed entries keep their result but lose every side effect
    new_entry.y          = bus.alu_y;
    new_entry.zero       = bus.alu_zero;
    new_entry.rd         = bus.rd;
    new_entry.reg_write  = bus.reg_write & ~kill;
    new_entry.mem_read   = bus.mem_read & ~kill;
    new_entry.mem_write  = bus.mem_write & ~kill;
    new_entry.store_data = bus.store_data;
    new_entry.killed     = kill;

    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (pop) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      // in_ready tracks an empty skid, so an accept never finds both slots full
      if (accept) begin
        if (!main_valid_q || (pop && !skid_valid_q)) begin
          main_d       = new_entry;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = new_entry;
          skid_valid_d = 1'b1;
        end
      end
    end

    in_ready_d = ~skid_valid_d;

    // A new trap beats a same-cycle acknowledge of the previous one
    raise         = accept & trap & ~bus.flush & (~exc_pending_q | bus.exc_ack);
    exc_valid_d   = raise;
    exc_pending_d = raise | (exc_pending_q & ~bus.exc_ack);
    exc_epc_d     = raise ? bus.pc : exc_epc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q        <= '0;
      skid_q        <= '0;
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      in_ready_q    <= 1'b1;
      exc_valid_q   <= 1'b0;
      exc_pending_q <= 1'b0;
      exc_epc_q     <= '0;
    end else begin
      main_q        <= main_d;
      skid_q        <= skid_d;
      main_valid_q  <= main_valid_d;
      skid_valid_q  <= skid_valid_d;
      in_ready_q    <= in_ready_d;
      exc_valid_q   <= exc_valid_d;
      exc_pending_q <= exc_pending_d;
      exc_epc_q     <= exc_epc_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = main_valid_q;
  assign bus.out_y          = main_q.y;
  assign bus.out_zero       = main_q.zero;
  assign bus.out_rd         = main_q.rd;
  assign bus.out_reg_write  = main_q.reg_write;
  assign bus.out_mem_read   = main_q.mem_read;
  assign bus.out_mem_write  = main_q.mem_write;
  assign bus.out_store_data = main_q.store_data;
  assign bus.out_killed     = main_q.killed;
  assign bus.exc_valid      = exc_valid_q;
  assign bus.exc_pending    = exc_pending_q;
  assign bus.exc_epc        = exc_epc_q;

endmodule

`default_nettype wire
